lii_stream_adapter: RTL and testbench

- Parametrised LII phy-to-kernel adapter for one HLS stage; successor to the fixed-width per-kernel wrappers.
- Input side: one LII input channel feeds an IW-bit kernel input stream through a DEPTH-entry FIFO, with destination-ID filtering and a saturating drop counter.
- Output side: the OW-bit kernel output stream is zero-extended to PW, stamped with src/dst IDs, and driven through a full-throughput skid slice.
- Generates the kernel clock enable from registered buffer state.

---
 rtl/lii_pkg.sv | 17 +
 rtl/lii_sync_fifo.sv | 56 +++++
 rtl/lii_stream_adapter.sv | 132 +++++++++++++
 tb/tb_lii_stream_adapter.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lii_pkg.sv
// Shared LII definitions: ID and counter widths, beat header layout and pointer sizing.
package lii_pkg;
  localparam int LII_ID_W   = 8;
  localparam int DROP_CNT_W = 16;

  typedef logic [LII_ID_W-1:0] lii_id_t;

  typedef struct packed {
    lii_id_t src;
    lii_id_t dst;
  } lii_hdr_t;

  // At least one pointer bit, even for a 2-entry FIFO.
  function automatic int ptr_w(input int depth);
    return (depth > 2) ? $clog2(depth) : 1;
  endfunction
endpackage

// File: rtl/lii_sync_fifo.sv
// First-word-fall-through synchronous FIFO with full/empty/count derived from a registered count.
module lii_sync_fifo
  import lii_pkg::*;
#(
  parameter int W     = 72,
  parameter int DEPTH = 4,
  localparam int PTR_W = ptr_w(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [W-1:0]     wr_data,
  input  logic             rd_en,
  output logic [W-1:0]     rd_data,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);
  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             push;
  logic             pop;

  assign full  = (count_reg == CNT_W'(DEPTH));
  assign empty = (count_reg == '0);
  assign count = count_reg;

  // Flags come from the registered count, so a same-cycle pop never frees a slot for a push.
  assign push = wr_en & ~full;
  assign pop  = rd_en & ~empty;

  assign rd_data = mem[rd_ptr_reg];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end
endmodule

// File: rtl/lii_stream_adapter.sv
// LII phy-to-kernel adapter: filtered FWFT input FIFO, stamped output skid slice and kernel clock enable.
module lii_stream_adapter
  import lii_pkg::*;
#(
  parameter int          PW        = 128,
  parameter int          IW        = 72,
  parameter int          OW        = 56,
  parameter int          DEPTH     = 4,
  parameter logic [7:0]  NODE_ID   = 8'h00,
  parameter logic [7:0]  DEST_ID   = 8'h00,
  parameter bit          FILTER_EN = 1'b1
) (
  input  logic                  aclk,
  input  logic                  arstn,
  input  logic [PW-1:0]         lii_in_p0_tdata,
  input  logic                  lii_in_p0_tvalid,
  output logic                  lii_in_p0_tready,
  input  logic [LII_ID_W-1:0]   lii_in_p0_src,
  input  logic [LII_ID_W-1:0]   lii_in_p0_dst,
  output logic [PW-1:0]         lii_out_p0_tdata,
  output logic                  lii_out_p0_tvalid,
  input  logic                  lii_out_p0_tready,
  output logic [LII_ID_W-1:0]   lii_out_p0_src,
  output logic [LII_ID_W-1:0]   lii_out_p0_dst,
  output logic [IW-1:0]         kin_tdata,
  output logic                  kin_tvalid,
  input  logic                  kin_tready,
  input  logic [OW-1:0]         kout_tdata,
  input  logic                  kout_tvalid,
  output logic                  kout_tready,
  output logic                  ce,
  output logic [DROP_CNT_W-1:0] drop_count
);
  localparam int CNT_W = ptr_w(DEPTH) + 1;

  logic             match;
  logic             fifo_full;
  logic             fifo_empty;
  logic             push;
  logic             drop;
  logic [CNT_W-1:0] unused_fifo_count;

  logic [DROP_CNT_W-1:0] drop_cnt_reg;
  logic [DROP_CNT_W-1:0] drop_cnt_next;

  logic          main_valid_reg;
  logic [OW-1:0] main_data_reg;
  logic          skid_valid_reg;
  logic [OW-1:0] skid_data_reg;
  logic          out_fire;
  logic          in_accept;

  lii_hdr_t out_hdr;

  // ---------------- input path ----------------
  assign match            = !FILTER_EN || (lii_in_p0_dst == NODE_ID);
  assign lii_in_p0_tready = arstn & (~fifo_full | ~match);
  assign push             = lii_in_p0_tvalid & lii_in_p0_tready & match;
  assign drop             = lii_in_p0_tvalid & lii_in_p0_tready & ~match;

  lii_sync_fifo #(
    .W     (IW),
    .DEPTH (DEPTH)
  ) u_in_fifo (
    .clk     (aclk),
    .rst_n   (arstn),
    .wr_en   (push),
    .wr_data (lii_in_p0_tdata[IW-1:0]),
    .rd_en   (kin_tvalid & kin_tready),
    .rd_data (kin_tdata),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (unused_fifo_count)
  );

  assign kin_tvalid = arstn & ~fifo_empty;

  assign drop_cnt_next = (drop && drop_cnt_reg != '1) ? drop_cnt_reg + 1'b1 : drop_cnt_reg;

  always_ff @(posedge aclk or negedge arstn) begin
    if (!arstn) drop_cnt_reg <= '0;
    else        drop_cnt_reg <= drop_cnt_next;
  end

  assign drop_count = drop_cnt_reg;

  // Source ID and the bits above IW carry nothing this stage needs.
  logic unused_in_bits;
  generate
    if (IW < PW) begin : g_in_upper
      assign unused_in_bits = ^{lii_in_p0_src, lii_in_p0_tdata[PW-1:IW], unused_fifo_count};
    end else begin : g_in_full
      assign unused_in_bits = ^{lii_in_p0_src, unused_fifo_count};
    end
  endgenerate

  // ---------------- output skid slice ----------------
  assign kout_tready = arstn & ~skid_valid_reg;
  assign in_accept   = kout_tvalid & kout_tready;
  assign out_fire    = main_valid_reg & lii_out_p0_tready;

  always_ff @(posedge aclk or negedge arstn) begin
    if (!arstn) begin
      main_valid_reg <= 1'b0;
      main_data_reg  <= '0;
      skid_valid_reg <= 1'b0;
      skid_data_reg  <= '0;
    end else if (out_fire || !main_valid_reg) begin
      // Main slot frees up: skid has priority so order is preserved.
      if (skid_valid_reg) begin
        main_valid_reg <= 1'b1;
        main_data_reg  <= skid_data_reg;
        skid_valid_reg <= 1'b0;
      end else begin
        main_valid_reg <= in_accept;
        if (in_accept) main_data_reg <= kout_tdata;
      end
    end else if (in_accept) begin
      skid_valid_reg <= 1'b1;
      skid_data_reg  <= kout_tdata;
    end
  end

  assign out_hdr           = '{src: NODE_ID, dst: DEST_ID};
  assign lii_out_p0_tvalid = main_valid_reg;
  assign lii_out_p0_tdata  = PW'(main_data_reg);
  assign lii_out_p0_src    = out_hdr.src;
  assign lii_out_p0_dst    = out_hdr.dst;

  // Kernel runs only when neither side is back-pressured; all terms are registered.
  assign ce = arstn & ~skid_valid_reg & ~fifo_full;
endmodule

// File: tb/tb_lii_stream_adapter.sv
// Directed, table-driven bench for lii_stream_adapter (NODE_ID=0, DEST_ID=3C, DEPTH=4).
module tb_lii_stream_adapter;
  localparam int PW = 128;
  localparam int IW = 72;
  localparam int OW = 56;

  logic          aclk = 1'b0;
  logic          arstn;
  logic [PW-1:0] lii_in_p0_tdata;
  logic          lii_in_p0_tvalid;
  logic          lii_in_p0_tready;
  logic [7:0]    lii_in_p0_src;
  logic [7:0]    lii_in_p0_dst;
  logic [PW-1:0] lii_out_p0_tdata;
  logic          lii_out_p0_tvalid;
  logic          lii_out_p0_tready;
  logic [7:0]    lii_out_p0_src;
  logic [7:0]    lii_out_p0_dst;
  logic [IW-1:0] kin_tdata;
  logic          kin_tvalid;
  logic          kin_tready;
  logic [OW-1:0] kout_tdata;
  logic          kout_tvalid;
  logic          kout_tready;
  logic          ce;
  logic [15:0]   drop_count;

  int checks = 0;
  int failures = 0;

  always #5 aclk = ~aclk;

  lii_stream_adapter #(
    .PW(PW), .IW(IW), .OW(OW), .DEPTH(4),
    .NODE_ID(8'h00), .DEST_ID(8'h3C), .FILTER_EN(1'b1)
  ) dut (
    .aclk(aclk), .arstn(arstn),
    .lii_in_p0_tdata(lii_in_p0_tdata), .lii_in_p0_tvalid(lii_in_p0_tvalid),
    .lii_in_p0_tready(lii_in_p0_tready), .lii_in_p0_src(lii_in_p0_src),
    .lii_in_p0_dst(lii_in_p0_dst),
    .lii_out_p0_tdata(lii_out_p0_tdata), .lii_out_p0_tvalid(lii_out_p0_tvalid),
    .lii_out_p0_tready(lii_out_p0_tready), .lii_out_p0_src(lii_out_p0_src),
    .lii_out_p0_dst(lii_out_p0_dst),
    .kin_tdata(kin_tdata), .kin_tvalid(kin_tvalid), .kin_tready(kin_tready),
    .kout_tdata(kout_tdata), .kout_tvalid(kout_tvalid), .kout_tready(kout_tready),
    .ce(ce), .drop_count(drop_count)
  );

  typedef struct {
    logic        v;
    logic [7:0]  dst;
    logic [71:0] data;
    logic        kr;
    logic        e_tr;
    logic        e_kv;
    logic [71:0] e_kd;
    logic        e_ce;
    logic [15:0] e_drop;
  } vec_t;

  vec_t tbl [16];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  function automatic vec_t mk(input logic v, input logic [7:0] dst, input logic [71:0] data,
                              input logic kr, input logic e_tr, input logic e_kv,
                              input logic [71:0] e_kd, input logic e_ce, input logic [15:0] e_drop);
    vec_t r;
    r.v = v; r.dst = dst; r.data = data; r.kr = kr; r.e_tr = e_tr; r.e_kv = e_kv;
    r.e_kd = e_kd; r.e_ce = e_ce; r.e_drop = e_drop;
    return r;
  endfunction

  logic [7:0]  st_rdy [7];
  logic [7:0]  st_kv  [7];
  logic [7:0]  st_kd  [7];
  logic [7:0]  st_ov  [7];
  logic [7:0]  st_od  [7];
  logic [7:0]  st_ktr [7];

  initial begin
    arstn = 1'b0;
    lii_in_p0_tdata = '0; lii_in_p0_tvalid = 1'b0; lii_in_p0_src = 8'hAA; lii_in_p0_dst = 8'h00;
    lii_out_p0_tready = 1'b0; kin_tready = 1'b0; kout_tdata = '0; kout_tvalid = 1'b0;

    // Input-side vectors: 6 matching beats against a stalled kernel, drain, then 3 filtered beats.
    tbl[0]  = mk(1, 8'h00, 72'd1,  0, 1, 1'b0, 72'd0, 1, 16'd0);
    tbl[1]  = mk(1, 8'h00, 72'd2,  0, 1, 1'b1, 72'd1, 1, 16'd0);
    tbl[2]  = mk(1, 8'h00, 72'd3,  0, 1, 1'b1, 72'd1, 1, 16'd0);
    tbl[3]  = mk(1, 8'h00, 72'd4,  0, 1, 1'b1, 72'd1, 1, 16'd0);
    tbl[4]  = mk(1, 8'h00, 72'd5,  0, 0, 1'b1, 72'd1, 0, 16'd0);
    tbl[5]  = mk(1, 8'h00, 72'd5,  1, 0, 1'b1, 72'd1, 0, 16'd0);
    tbl[6]  = mk(1, 8'h00, 72'd5,  1, 1, 1'b1, 72'd2, 1, 16'd0);
    tbl[7]  = mk(1, 8'h00, 72'd6,  1, 1, 1'b1, 72'd3, 1, 16'd0);
    tbl[8]  = mk(0, 8'h00, 72'd0,  1, 1, 1'b1, 72'd4, 1, 16'd0);
    tbl[9]  = mk(0, 8'h00, 72'd0,  1, 1, 1'b1, 72'd5, 1, 16'd0);
    tbl[10] = mk(0, 8'h00, 72'd0,  1, 1, 1'b1, 72'd6, 1, 16'd0);
    tbl[11] = mk(0, 8'h00, 72'd0,  1, 1, 1'b0, 72'd0, 1, 16'd0);
    tbl[12] = mk(1, 8'h05, 72'h77, 1, 1, 1'b0, 72'd0, 1, 16'd0);
    tbl[13] = mk(1, 8'h05, 72'h78, 1, 1, 1'b0, 72'd0, 1, 16'd1);
    tbl[14] = mk(1, 8'h05, 72'h79, 1, 1, 1'b0, 72'd0, 1, 16'd2);
    tbl[15] = mk(0, 8'h05, 72'h00, 1, 1, 1'b0, 72'd0, 1, 16'd3);

    // During reset every control output is held low.
    @(negedge aclk);
    chk("rst_in_tready", lii_in_p0_tready, 0);
    chk("rst_kin_tvalid", kin_tvalid, 0);
    chk("rst_kout_tready", kout_tready, 0);
    chk("rst_ce", ce, 0);
    step();
    arstn = 1'b1;
    step();
    @(negedge aclk);
    chk("idle_in_tready", lii_in_p0_tready, 1);
    chk("idle_kin_tvalid", kin_tvalid, 0);
    chk("idle_kout_tready", kout_tready, 1);
    chk("idle_out_tvalid", lii_out_p0_tvalid, 0);
    chk("idle_ce", ce, 1);
    chk("idle_drop", drop_count, 0);
    chk("idle_src", lii_out_p0_src, 8'h00);
    chk("idle_dst", lii_out_p0_dst, 8'h3C);

    // Table-driven input path; upper phy bits carry junk that must not reach the kernel.
    for (int i = 0; i < 16; i++) begin
      step();
      lii_in_p0_tvalid = tbl[i].v;
      lii_in_p0_dst    = tbl[i].dst;
      lii_in_p0_tdata  = {56'hDE_ADBE_EF00_1234, tbl[i].data};
      kin_tready       = tbl[i].kr;
      @(negedge aclk);
      $display("vec %0d: v=%0b dst=%0h data=%0h kr=%0b tready=%0b kv=%0b kd=%0h ce=%0b drop=%0d",
               i, tbl[i].v, tbl[i].dst, tbl[i].data, tbl[i].kr, lii_in_p0_tready,
               kin_tvalid, kin_tdata, ce, drop_count);
      chk($sformatf("vec%0d_tready", i), lii_in_p0_tready, tbl[i].e_tr);
      chk($sformatf("vec%0d_kin_tvalid", i), kin_tvalid, tbl[i].e_kv);
      if (tbl[i].e_kv) chk($sformatf("vec%0d_kin_tdata", i), kin_tdata, tbl[i].e_kd);
      chk($sformatf("vec%0d_ce", i), ce, tbl[i].e_ce);
      chk($sformatf("vec%0d_drop", i), drop_count, tbl[i].e_drop);
    end

    // Drop counter saturation from FFFE.
    step();
    lii_in_p0_tvalid = 1'b0;
    force dut.drop_cnt_reg = 16'hFFFE;
    @(negedge aclk);
    release dut.drop_cnt_reg;
    for (int i = 0; i < 4; i++) begin
      step();
      lii_in_p0_tvalid = (i < 3);
      lii_in_p0_dst    = 8'h05;
      @(negedge aclk);
      $display("sat %0d: drop=%0h", i, drop_count);
      chk($sformatf("sat%0d_drop", i), drop_count, (i == 0) ? 16'hFFFE : 16'hFFFF);
      chk($sformatf("sat%0d_kin_tvalid", i), kin_tvalid, 0);
    end
    step();
    lii_in_p0_tvalid = 1'b0;
    lii_in_p0_dst    = 8'h00;

    // Continuous output stream with ready held high.
    lii_out_p0_tready = 1'b1;
    for (int i = 0; i <= 16; i++) begin
      if (i > 0) step();
      kout_tvalid = (i < 16);
      kout_tdata  = OW'(8'hA0 + i);
      @(negedge aclk);
      $display("stream %0d: out_v=%0b out_d=%0h kout_tready=%0b", i, lii_out_p0_tvalid,
               lii_out_p0_tdata, kout_tready);
      chk($sformatf("str%0d_kout_tready", i), kout_tready, 1);
      chk($sformatf("str%0d_out_tvalid", i), lii_out_p0_tvalid, (i > 0));
      if (i > 0) chk($sformatf("str%0d_out_tdata", i), lii_out_p0_tdata, 128'(8'hA0 + i - 1));
    end
    chk("str_src", lii_out_p0_src, 8'h00);
    chk("str_dst", lii_out_p0_dst, 8'h3C);

    // Back-pressure into the skid slot: ready pattern 1,0,0,1 after the first beat.
    st_rdy = '{1, 1, 0, 0, 1, 1, 1};
    st_kv  = '{1, 1, 1, 0, 0, 0, 0};
    st_kd  = '{8'h10, 8'h11, 8'h12, 0, 0, 0, 0};
    st_ov  = '{0, 1, 1, 1, 1, 1, 0};
    st_od  = '{0, 8'h10, 8'h11, 8'h11, 8'h11, 8'h12, 0};
    st_ktr = '{1, 1, 1, 0, 0, 1, 1};
    for (int i = 0; i < 7; i++) begin
      step();
      lii_out_p0_tready = st_rdy[i][0];
      kout_tvalid       = st_kv[i][0];
      kout_tdata        = OW'(st_kd[i]);
      @(negedge aclk);
      $display("stall %0d: rdy=%0b out_v=%0b out_d=%0h kout_tready=%0b ce=%0b", i,
               lii_out_p0_tready, lii_out_p0_tvalid, lii_out_p0_tdata, kout_tready, ce);
      chk($sformatf("stall%0d_out_tvalid", i), lii_out_p0_tvalid, st_ov[i][0]);
      if (st_ov[i][0]) chk($sformatf("stall%0d_out_tdata", i), lii_out_p0_tdata, 128'(st_od[i]));
      chk($sformatf("stall%0d_kout_tready", i), kout_tready, st_ktr[i][0]);
      chk($sformatf("stall%0d_ce", i), ce, st_ktr[i][0]);
    end

    // Mid-transfer reset with 3 FIFO entries and the skid full.
    lii_out_p0_tready = 1'b0;
    kin_tready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      lii_in_p0_tvalid = 1'b1;
      lii_in_p0_dst    = 8'h00;
      lii_in_p0_tdata  = 128'(8'h21 + i);
      kout_tvalid      = (i < 2);
      kout_tdata       = OW'(8'h31 + i);
    end
    step();
    lii_in_p0_tvalid = 1'b0;
    kout_tvalid      = 1'b0;
    @(negedge aclk);
    $display("prerst: kin_v=%0b out_v=%0b kout_tready=%0b", kin_tvalid, lii_out_p0_tvalid, kout_tready);
    chk("prerst_kin_tvalid", kin_tvalid, 1);
    chk("prerst_kout_tready", kout_tready, 0);
    chk("prerst_out_tdata", lii_out_p0_tdata, 128'h31);
    step();
    arstn = 1'b0;
    @(negedge aclk);
    $display("inrst: kin_v=%0b out_v=%0b tready=%0b kout_tready=%0b ce=%0b", kin_tvalid,
             lii_out_p0_tvalid, lii_in_p0_tready, kout_tready, ce);
    chk("inrst_kin_tvalid", kin_tvalid, 0);
    chk("inrst_out_tvalid", lii_out_p0_tvalid, 0);
    chk("inrst_in_tready", lii_in_p0_tready, 0);
    chk("inrst_kout_tready", kout_tready, 0);
    chk("inrst_ce", ce, 0);
    step();
    arstn = 1'b1;
    lii_out_p0_tready = 1'b1;
    kin_tready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge aclk);
      $display("postrst %0d: kin_v=%0b out_v=%0b ce=%0b drop=%0d", i, kin_tvalid,
               lii_out_p0_tvalid, ce, drop_count);
      chk($sformatf("postrst%0d_kin_tvalid", i), kin_tvalid, 0);
      chk($sformatf("postrst%0d_out_tvalid", i), lii_out_p0_tvalid, 0);
      chk($sformatf("postrst%0d_ce", i), ce, 1);
      chk($sformatf("postrst%0d_drop", i), drop_count, 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
